// File: rtl/alu_wb_stage.sv
// ALU write-back stage: 2-entry result FIFO between ALU and register file,
// with the architectural V,N,Z,C flags register updated as entries retire.
module alu_wb_stage #(
    parameter int n  = 8,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [n-1:0]  in_result,
    input  logic [3:0]    in_flags,
    input  logic [2:0]    in_func,
    input  logic [RW-1:0] in_rd,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [n-1:0]  out_result,
    output logic [RW-1:0] out_rd,
    output logic [3:0]    flags_q
);

    // Shared ALU function codes
    localparam logic [2:0] RA   = 3'd0;
    localparam logic [2:0] RB   = 3'd1;
    localparam logic [2:0] RADD = 3'd2;
    localparam logic [2:0] RSUB = 3'd3;
    localparam logic [2:0] RAND = 3'd4;
    localparam logic [2:0] ROR  = 3'd5;
    localparam logic [2:0] RXOR = 3'd6;
    localparam logic [2:0] MUL  = 3'd7;

    typedef struct packed {
        logic [n-1:0]  result;
        logic [3:0]    flags;
        logic [2:0]    func;
        logic [RW-1:0] rd;
    } entry_t;

    entry_t [1:0] mem;
    logic         wptr, rptr;
    logic [1:0]   count;
    logic         push, pop;
    entry_t       head;
    logic [3:0]   flags_d;

    // Handshake flags depend on registered count only; no out_ready -> in_ready path.
    assign in_ready   = (count < 2'd2);
    assign out_valid  = (count != 2'd0);
    assign head       = mem[rptr];
    assign out_result = head.result;
    assign out_rd     = head.rd;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        flags_d = flags_q;
        if (pop) begin
            case (head.func)
                RADD, RSUB:             flags_d = head.flags;
                RAND, ROR, RXOR, MUL:   flags_d[2:1] = head.flags[2:1];
                RA, RB:                 flags_d = flags_q;
                default:                flags_d = flags_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mem     <= '0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            count   <= 2'd0;
            flags_q <= 4'b0000;
        end else if (flush) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= '{result: in_result, flags: in_flags, func: in_func, rd: in_rd};
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: vector table for FIFO/flag behaviour plus
// hand sequences for streaming, flush and asynchronous reset.
module tb_alu_wb_stage;

    localparam logic [2:0] RA   = 3'd0;
    localparam logic [2:0] RB   = 3'd1;
    localparam logic [2:0] RADD = 3'd2;
    localparam logic [2:0] RSUB = 3'd3;
    localparam logic [2:0] RAND = 3'd4;
    localparam logic [2:0] ROR  = 3'd5;
    localparam logic [2:0] RXOR = 3'd6;
    localparam logic [2:0] MUL  = 3'd7;

    logic       clk = 1'b0;
    logic       nReset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [7:0] in_result, out_result;
    logic [3:0] in_flags, flags_q;
    logic [2:0] in_func, in_rd, out_rd;

    int n_checks = 0;
    int n_errors = 0;

    alu_wb_stage #(.n(8), .RW(3)) dut (
        .clk(clk), .nReset(nReset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_func(in_func), .in_rd(in_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] res;
        logic [3:0] fl;
        logic [2:0] fn;
        logic [2:0] rd;
        logic       ordy;
        logic       e_ov;
        logic       e_ir;
        logic [7:0] e_res;
        logic [2:0] e_rd;
        logic [3:0] e_fl;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] res, input logic [3:0] fl,
                         input logic [2:0] fn, input logic [2:0] rd, input logic ordy,
                         input logic fsh);
        in_valid  = iv;
        in_result = res;
        in_flags  = fl;
        in_func   = fn;
        in_rd     = rd;
        out_ready = ordy;
        flush     = fsh;
    endtask

    // Drive at negedge, let one rising edge pass, come back to the next negedge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //             iv  res    fl       fn    rd  ordy ov  ir  ores   ord  flags
        tbl[0]  = '{1, 8'h80, 4'b1101, RADD, 3, 1, 1, 1, 8'h80, 3, 4'b0000};
        tbl[1]  = '{0, 8'h00, 4'b0000, RA,   0, 1, 0, 1, 8'h00, 0, 4'b1101};
        tbl[2]  = '{1, 8'h01, 4'b0000, RA,   1, 0, 1, 1, 8'h01, 1, 4'b1101};
        tbl[3]  = '{1, 8'h02, 4'b0000, RA,   2, 0, 1, 0, 8'h01, 1, 4'b1101};
        tbl[4]  = '{1, 8'h03, 4'b0000, RA,   3, 0, 1, 0, 8'h01, 1, 4'b1101};
        tbl[5]  = '{1, 8'h03, 4'b0000, RA,   3, 1, 1, 1, 8'h02, 2, 4'b1101};
        tbl[6]  = '{1, 8'h03, 4'b0000, RA,   3, 1, 1, 1, 8'h03, 3, 4'b1101};
        tbl[7]  = '{0, 8'h00, 4'b0000, RA,   0, 1, 0, 1, 8'h00, 0, 4'b1101};
        tbl[8]  = '{1, 8'h10, 4'b1001, RADD, 4, 0, 1, 1, 8'h10, 4, 4'b1101};
        tbl[9]  = '{1, 8'h20, 4'b0010, RXOR, 5, 1, 1, 1, 8'h20, 5, 4'b1001};
        tbl[10] = '{1, 8'h30, 4'b0100, RB,   6, 1, 1, 1, 8'h30, 6, 4'b1011};
        tbl[11] = '{0, 8'h00, 4'b0000, RA,   0, 1, 0, 1, 8'h00, 0, 4'b1011};
        tbl[12] = '{1, 8'h55, 4'b1110, MUL,  0, 0, 1, 1, 8'h55, 0, 4'b1011};
        tbl[13] = '{1, 8'h66, 4'b0001, RSUB, 1, 1, 1, 1, 8'h66, 1, 4'b1111};
        tbl[14] = '{0, 8'h00, 4'b0000, RA,   0, 1, 0, 1, 8'h00, 0, 4'b0001};
        tbl[15] = '{1, 8'h77, 4'b0110, RAND, 2, 0, 1, 1, 8'h77, 2, 4'b0001};
        tbl[16] = '{1, 8'h88, 4'b1000, ROR,  3, 1, 1, 1, 8'h88, 3, 4'b0111};
        tbl[17] = '{0, 8'h00, 4'b0000, RA,   0, 1, 0, 1, 8'h00, 0, 4'b0001};

        // Reset state
        nReset = 1'b0;
        drive(0, 8'h00, 4'h0, RA, 0, 0, 0);
        cycle();
        cycle();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_flags", flags_q, 4'b0000);
        check("rst_out_result", out_result, 8'h00);
        check("rst_out_rd", out_rd, 3'd0);
        nReset = 1'b1;
        cycle();

        // Vector table: single pass, backpressure ordering, flag masking per func
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].iv, tbl[i].res, tbl[i].fl, tbl[i].fn, tbl[i].rd, tbl[i].ordy, 0);
            cycle();
            check($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
            check($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
            check($sformatf("v%0d_flags", i), flags_q, tbl[i].e_fl);
            if (tbl[i].e_ov) begin
                check($sformatf("v%0d_out_result", i), out_result, tbl[i].e_res);
                check($sformatf("v%0d_out_rd", i), out_rd, tbl[i].e_rd);
            end
        end

        // Streaming: push and pop every cycle, each output the value pushed one edge earlier
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'hA0 + 8'(i), 4'b0000, RA, 3'(i), 1, 0);
            cycle();
            check($sformatf("s%0d_in_ready", i), in_ready, 1);
            check($sformatf("s%0d_out_valid", i), out_valid, 1);
            check($sformatf("s%0d_out_result", i), out_result, 8'hA0 + 8'(i));
        end
        drive(0, 8'h00, 4'h0, RA, 0, 1, 0);
        cycle();
        check("s_drain_out_valid", out_valid, 0);

        // Flush with two entries held, concurrent push and pop requested
        drive(1, 8'hC1, 4'b1110, RADD, 1, 0, 0);
        cycle();
        drive(1, 8'hC2, 4'b1110, RADD, 2, 0, 0);
        cycle();
        check("f_full_in_ready", in_ready, 0);
        drive(1, 8'hC3, 4'b1110, RADD, 3, 1, 1);
        cycle();
        check("f_out_valid", out_valid, 0);
        check("f_in_ready", in_ready, 1);
        check("f_flags", flags_q, 4'b0001);
        drive(1, 8'hD4, 4'b0000, RA, 4, 0, 0);
        cycle();
        check("f_after_result", out_result, 8'hD4);
        check("f_after_rd", out_rd, 3'd4);
        drive(0, 8'h00, 4'h0, RA, 0, 1, 0);
        cycle();
        check("f_after_empty", out_valid, 0);

        // Async reset between edges with two entries held
        drive(1, 8'hE1, 4'b0000, RA, 1, 0, 0);
        cycle();
        drive(1, 8'hE2, 4'b0000, RA, 2, 0, 0);
        cycle();
        drive(0, 8'h00, 4'h0, RA, 0, 0, 0);
        check("a_pre_out_valid", out_valid, 1);
        #1 nReset = 1'b0;
        #1;
        check("a_out_valid", out_valid, 0);
        check("a_flags", flags_q, 4'b0000);
        check("a_in_ready", in_ready, 1);
        check("a_out_result", out_result, 8'h00);
        #1 nReset = 1'b1;
        @(negedge clk);
        drive(1, 8'hF5, 4'b1111, RSUB, 5, 0, 0);
        cycle();
        check("a_resume_result", out_result, 8'hF5);
        drive(0, 8'h00, 4'h0, RA, 0, 1, 0);
        cycle();
        check("a_resume_flags", flags_q, 4'b1111);
        check("a_resume_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 The block SHALL have parameter n, default 8, meaning datapath width, matching the ALU width.
REQ-002 The block SHALL have parameter RW, default 3, meaning destination register address width.
REQ-003 Port clk SHALL be input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port nReset SHALL be input, 1 bit, reset, asynchronous and active-low.
REQ-005 Port in_valid SHALL be input, 1 bit, meaning an ALU result is presented.
REQ-006 Port in_ready SHALL be output, 1 bit, meaning the stage accepts the presented result this cycle.
REQ-007 Port in_result SHALL be input, n bits, meaning ALU result.
REQ-008 Port in_flags SHALL be input, 4 bits, meaning ALU flags ordered [3]=V, [2]=N, [1]=Z, [0]=C.
REQ-009 Port in_func SHALL be input, 3 bits, meaning the ALU function code that produced the result, using the shared ALU code definitions.
REQ-010 Port in_rd SHALL be input, RW bits, meaning destination register address.
REQ-011 Port flush SHALL be input, 1 bit, meaning a synchronous discard of all buffered entries.
REQ-012 Port out_valid SHALL be output, 1 bit, meaning a write-back entry is presented.
REQ-013 Port out_ready SHALL be input, 1 bit, meaning the register file consumes the entry this cycle.
REQ-014 Port out_result SHALL be output, n bits, meaning write-back data.
REQ-015 Port out_rd SHALL be output, RW bits, meaning write-back register address.
REQ-016 Port flags_q SHALL be output, 4 bits, meaning the architectural flags register (V,N,Z,C), used by branch logic.

Function
REQ-017 The stage SHALL hold a 2-entry FIFO of {result, flags, func, rd}; an entry is pushed when in_valid && in_ready, and popped when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < 2), derived from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count > 0); out_result and out_rd SHALL come from the oldest entry.
REQ-020 Latency SHALL be 1 cycle: an entry pushed at edge k is presented on out_* after edge k.
REQ-021 Throughput SHALL be 1 entry per cycle: with count=1, a simultaneous push and pop leaves count=1 and preserves ordering.
REQ-022 When count=2, in_ready=0 and in_valid SHALL be ignored; a pop in that cycle leaves count=1.
REQ-023 A pop when count=0 cannot occur, because out_valid=0; read and write pointers SHALL wrap modulo 2.
REQ-024 On pop with func RADD or RSUB, flags_q SHALL load all four popped flags.
REQ-025 On pop with func RAND, ROR, RXOR or MUL, flags_q[2:1] (N,Z) SHALL load the popped flags; V and C SHALL be retained.
REQ-026 On pop with func RA or RB, flags_q SHALL be unchanged.
REQ-027 flush=1 SHALL set count=0 and discard any push or pop in that cycle; flags_q SHALL be unchanged, and no flags update occurs even if out_ready=1.
REQ-028 Data fields SHALL pass unmodified; no arithmetic is performed on result or rd.

Reset
REQ-029 While nReset=0, count=0, the pointers SHALL be 0, flags_q=4'b0000, out_valid=0, in_ready=1, and out_result/out_rd SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard all entries immediately (asynchronously); normal operation resumes at the first rising edge after nReset returns to 1.

Verification
REQ-031 Single pass: push RADD result 8'h80 with flags 4'b1101 and rd=3, out_ready=1 -> next cycle out_valid=1, out_result=8'h80, out_rd=3; after the pop, flags_q=4'b1101.
REQ-032 Backpressure: out_ready=0 and 3 pushes attempted (8'h01, 8'h02, 8'h03) -> in_ready=0 after 2 accepts; 8'h03 is held at the source; on releasing out_ready, the outputs are 8'h01, 8'h02, 8'h03 in order.
REQ-033 Streaming: in_valid=1 and out_ready=1 for 10 cycles -> in_ready stays 1, count stays ≤1, one output per cycle, with no loss or duplication.
REQ-034 Flag masking: flags_q=4'b1001, then pop RXOR with flags 4'b0010 -> flags_q=4'b1011; then pop RB with flags 4'b0100 -> flags_q=4'b1011.
REQ-035 Flush: 2 entries held, and flush=1 with out_ready=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, flags_q unchanged.
REQ-036 Async reset: nReset pulsed low between edges with 2 entries held -> out_valid=0 and flags_q=0 immediately, before the next edge.
